// File: rtl/cpe_lsu.sv
// cpe_lsu: single-outstanding load/store unit for the core's memory port.
// Aligns and lanes requests, extends loads, and aborts stalled accesses.
module cpe_lsu #(
    parameter int XLEN    = 32,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk_w_i,
    input  logic              res_w_i_l,
    input  logic              req_w_i_h,
    input  logic              we_w_i_h,
    input  logic [2:0]        funct_3_w_i,
    input  logic [ADDR_W-1:0] addr_w_i,
    input  logic [XLEN-1:0]   wr_data_w_i,
    output logic              busy_w_o_h,
    output logic              done_w_o_h,
    output logic [XLEN-1:0]   rd_data_w_o,
    output logic              misalign_w_o_h,
    output logic              err_w_o_h,
    output logic              mem_req_w_o_h,
    output logic              mem_wr_w_o_h,
    output logic [ADDR_W-1:0] mem_addr_w_o,
    output logic [XLEN/8-1:0] mem_be_w_o,
    output logic [XLEN-1:0]   mem_wdata_w_o,
    input  logic              mem_ack_w_i_h,
    input  logic [XLEN-1:0]   mem_rdata_w_i,
    input  logic              mem_err_w_i_h
);
    localparam int BE_W = XLEN / 8;
    localparam int LB   = $clog2(BE_W);
    localparam logic [16:0] TMO = 17'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, MEM, DONE} state_t;

    state_t              state_q, state_d;
    logic                we_q, we_d;
    logic [2:0]          f3_q, f3_d;
    logic [LB-1:0]       lane_q, lane_d;
    logic [15:0]         cnt_q, cnt_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [XLEN-1:0]     rd_data_q, rd_data_d;
    logic                mis_q, mis_d;
    logic                err_q, err_d;
    logic                mreq_q, mreq_d;
    logic                mwr_q, mwr_d;
    logic [ADDR_W-1:0]   maddr_q, maddr_d;
    logic [BE_W-1:0]     mbe_q, mbe_d;
    logic [XLEN-1:0]     mwdata_q, mwdata_d;

    logic [LB-1:0]       in_lane;
    int                  in_nb;
    logic                in_mis;
    logic                in_legal;
    logic [BE_W-1:0]     in_be;
    logic [XLEN-1:0]     shifted;
    logic [XLEN-1:0]     ext;
    int                  ld_nb;
    logic                ld_msb;

    // Request-side decode: lane, size, alignment and legality
    always_comb begin
        in_lane = addr_w_i[LB-1:0];
        in_nb   = 1 << funct_3_w_i[1:0];
        unique case (funct_3_w_i[1:0])
            2'b00:   in_mis = 1'b0;
            2'b01:   in_mis = addr_w_i[0];
            2'b10:   in_mis = |addr_w_i[1:0];
            default: in_mis = |addr_w_i[2:0];
        endcase
        if (we_w_i_h) begin
            unique case (funct_3_w_i)
                3'b000, 3'b001, 3'b010: in_legal = 1'b1;
                3'b011:                 in_legal = (XLEN == 64);
                default:                in_legal = 1'b0;
            endcase
        end else begin
            unique case (funct_3_w_i)
                3'b000, 3'b001, 3'b010,
                3'b100, 3'b101:         in_legal = 1'b1;
                3'b011, 3'b110:         in_legal = (XLEN == 64);
                default:                in_legal = 1'b0;
            endcase
        end
        for (int i = 0; i < BE_W; i++) begin
            in_be[i] = (i >= int'(in_lane)) && (i < int'(in_lane) + in_nb);
        end
    end

    // Load extraction: pick the field at the lane, then extend
    always_comb begin
        shifted = mem_rdata_w_i >> {lane_q, 3'b000};
        unique case (f3_q[1:0])
            2'b00: begin ld_nb = 8;  ld_msb = shifted[7];  end
            2'b01: begin ld_nb = 16; ld_msb = shifted[15]; end
            2'b10: begin ld_nb = 32; ld_msb = shifted[31]; end
            default: begin ld_nb = XLEN; ld_msb = shifted[XLEN-1]; end
        endcase
        for (int i = 0; i < XLEN; i++) begin
            ext[i] = (i < ld_nb) ? shifted[i] : (~f3_q[2] & ld_msb);
        end
    end

    always_comb begin
        state_d   = state_q;
        we_d      = we_q;
        f3_d      = f3_q;
        lane_d    = lane_q;
        cnt_d     = cnt_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        rd_data_d = rd_data_q;
        mis_d     = 1'b0;
        err_d     = 1'b0;
        mreq_d    = mreq_q;
        mwr_d     = mwr_q;
        maddr_d   = maddr_q;
        mbe_d     = mbe_q;
        mwdata_d  = mwdata_q;
        unique case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (req_w_i_h) begin
                    we_d   = we_w_i_h;
                    f3_d   = funct_3_w_i;
                    lane_d = in_lane;
                    if (in_mis || !in_legal) begin
                        state_d   = DONE;
                        done_d    = 1'b1;
                        mis_d     = in_mis;
                        err_d     = !in_mis;
                        rd_data_d = '0;
                    end else begin
                        state_d  = MEM;
                        busy_d   = 1'b1;
                        cnt_d    = '0;
                        mreq_d   = 1'b1;
                        mwr_d    = we_w_i_h;
                        maddr_d  = {addr_w_i[ADDR_W-1:LB], {LB{1'b0}}};
                        mbe_d    = in_be;
                        mwdata_d = wr_data_w_i << {in_lane, 3'b000};
                    end
                end
            end
            MEM: begin
                if (mem_ack_w_i_h) begin
                    state_d   = DONE;
                    done_d    = 1'b1;
                    busy_d    = 1'b0;
                    mreq_d    = 1'b0;
                    mwr_d     = 1'b0;
                    err_d     = mem_err_w_i_h;
                    rd_data_d = we_q ? '0 : ext;
                end else if (({1'b0, cnt_q} + 17'd1) == TMO) begin
                    state_d   = DONE;
                    done_d    = 1'b1;
                    busy_d    = 1'b0;
                    mreq_d    = 1'b0;
                    mwr_d     = 1'b0;
                    err_d     = 1'b1;
                    rd_data_d = '0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_w_i or negedge res_w_i_l) begin
        if (!res_w_i_l) begin
            state_q   <= IDLE;
            we_q      <= 1'b0;
            f3_q      <= '0;
            lane_q    <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            rd_data_q <= '0;
            mis_q     <= 1'b0;
            err_q     <= 1'b0;
            mreq_q    <= 1'b0;
            mwr_q     <= 1'b0;
            maddr_q   <= '0;
            mbe_q     <= '0;
            mwdata_q  <= '0;
        end else begin
            state_q   <= state_d;
            we_q      <= we_d;
            f3_q      <= f3_d;
            lane_q    <= lane_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            rd_data_q <= rd_data_d;
            mis_q     <= mis_d;
            err_q     <= err_d;
            mreq_q    <= mreq_d;
            mwr_q     <= mwr_d;
            maddr_q   <= maddr_d;
            mbe_q     <= mbe_d;
            mwdata_q  <= mwdata_d;
        end
    end

    assign busy_w_o_h     = busy_q;
    assign done_w_o_h     = done_q;
    assign rd_data_w_o    = rd_data_q;
    assign misalign_w_o_h = mis_q;
    assign err_w_o_h      = err_q;
    assign mem_req_w_o_h  = mreq_q;
    assign mem_wr_w_o_h   = mwr_q;
    assign mem_addr_w_o   = maddr_q;
    assign mem_be_w_o     = mbe_q;
    assign mem_wdata_w_o  = mwdata_q;

endmodule

// File: tb/tb_cpe_lsu.sv
// tb_cpe_lsu: directed vectors for cpe_lsu at XLEN=32 (TIMEOUT=4)
// and XLEN=64, with hand-computed expectations.
module tb_cpe_lsu;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        req, we, ack, merr;
    logic [2:0]  f3;
    logic [31:0] addr, wdata, rdata;
    logic        busy, done, mis, err, mreq, mwr;
    logic [31:0] rd, maddr, mwdata;
    logic [3:0]  mbe;

    logic        req64, we64, ack64, merr64;
    logic [2:0]  f3_64;
    logic [31:0] addr64, maddr64;
    logic [63:0] wdata64, rdata64, rd64, mwdata64;
    logic        busy64, done64, mis64, err64, mreq64, mwr64;
    logic [7:0]  mbe64;

    int n_chk  = 0;
    int n_pass = 0;

    cpe_lsu #(.XLEN(32), .ADDR_W(32), .TIMEOUT(4)) u_dut32 (
        .clk_w_i(clk), .res_w_i_l(rst_n),
        .req_w_i_h(req), .we_w_i_h(we), .funct_3_w_i(f3),
        .addr_w_i(addr), .wr_data_w_i(wdata),
        .busy_w_o_h(busy), .done_w_o_h(done), .rd_data_w_o(rd),
        .misalign_w_o_h(mis), .err_w_o_h(err),
        .mem_req_w_o_h(mreq), .mem_wr_w_o_h(mwr),
        .mem_addr_w_o(maddr), .mem_be_w_o(mbe),
        .mem_wdata_w_o(mwdata), .mem_ack_w_i_h(ack),
        .mem_rdata_w_i(rdata), .mem_err_w_i_h(merr)
    );

    cpe_lsu #(.XLEN(64), .ADDR_W(32)) u_dut64 (
        .clk_w_i(clk), .res_w_i_l(rst_n),
        .req_w_i_h(req64), .we_w_i_h(we64), .funct_3_w_i(f3_64),
        .addr_w_i(addr64), .wr_data_w_i(wdata64),
        .busy_w_o_h(busy64), .done_w_o_h(done64), .rd_data_w_o(rd64),
        .misalign_w_o_h(mis64), .err_w_o_h(err64),
        .mem_req_w_o_h(mreq64), .mem_wr_w_o_h(mwr64),
        .mem_addr_w_o(maddr64), .mem_be_w_o(mbe64),
        .mem_wdata_w_o(mwdata64), .mem_ack_w_i_h(ack64),
        .mem_rdata_w_i(rdata64), .mem_err_w_i_h(merr64)
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int  nreq;
        logic seen, to_err;
        rst_n = 1'b1;
        req = 0; we = 0; f3 = 0; addr = 0; wdata = 0;
        ack = 0; merr = 0; rdata = 0;
        req64 = 0; we64 = 0; f3_64 = 0; addr64 = 0; wdata64 = 0;
        ack64 = 0; merr64 = 0; rdata64 = 0;
        #1 rst_n = 1'b0;
        #2;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_mreq", mreq, 0);
        check("rst_be", mbe, 0);
        check("rst_rd", rd, 0);
        check("rst_err", err, 0);
        check("rst_mreq64", mreq64, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // LB at 0x103, ack already present on the first MEM cycle
        req = 1; we = 0; f3 = 3'b000; addr = 32'h103;
        rdata = 32'h80FF_0000; ack = 1;
        step();
        req = 0;
        check("lb_busy", busy, 1);
        check("lb_mreq", mreq, 1);
        check("lb_addr", maddr, 32'h100);
        check("lb_be", mbe, 4'b1000);
        check("lb_mwr", mwr, 0);
        step();
        check("lb_done", done, 1);
        check("lb_busy_done", busy, 0);
        check("lb_rd", rd, 32'hFFFF_FF80);
        check("lb_err", err, 0);
        check("lb_mreq_drop", mreq, 0);
        ack = 0;
        step();
        check("lb_done_clr", done, 0);

        // SH at 0x202 with one stalled cycle
        req = 1; we = 1; f3 = 3'b001; addr = 32'h202; wdata = 32'h0000_BEEF;
        step();
        req = 0;
        check("sh_be", mbe, 4'b1100);
        check("sh_wdata", mwdata, 32'hBEEF_0000);
        check("sh_mwr", mwr, 1);
        check("sh_addr", maddr, 32'h200);
        step();
        check("sh_hold_req", mreq, 1);
        check("sh_hold_be", mbe, 4'b1100);
        ack = 1;
        step();
        ack = 0;
        check("sh_done", done, 1);
        check("sh_rd", rd, 0);
        check("sh_err", err, 0);
        step();

        // misaligned LW
        req = 1; we = 0; f3 = 3'b010; addr = 32'h101;
        step();
        req = 0;
        check("mis_done", done, 1);
        check("mis_flag", mis, 1);
        check("mis_mreq", mreq, 0);
        check("mis_err", err, 0);
        step();
        check("mis_clr", mis, 0);
        check("mis_done_clr", done, 0);

        // illegal funct3 011 on a 32-bit unit
        req = 1; f3 = 3'b011; addr = 32'h100;
        step();
        req = 0;
        check("ill_done", done, 1);
        check("ill_err", err, 1);
        check("ill_mis", mis, 0);
        check("ill_mreq", mreq, 0);
        step();
        check("ill_clr", err, 0);

        // timeout with ack held low
        req = 1; f3 = 3'b010; addr = 32'h400; ack = 0;
        step();
        req = 0;
        nreq = 0; seen = 0; to_err = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (mreq) nreq++;
            if (done) begin
                seen = 1;
                to_err = err;
            end else begin
                step();
            end
        end
        check("to_seen", seen, 1);
        check("to_cycles", nreq, 4);
        check("to_err", to_err, 1);
        step();

        // ack in the 4th MEM cycle; a req pulse while busy is dropped
        req = 1; f3 = 3'b010; addr = 32'h500; rdata = 32'h1122_3344;
        step();
        req = 1; addr = 32'h600;
        step();
        req = 0;
        check("bsy_addr", maddr, 32'h500);
        step();
        step();
        ack = 1;
        step();
        ack = 0;
        check("a4_done", done, 1);
        check("a4_err", err, 0);
        check("a4_rd", rd, 32'h1122_3344);
        step();
        check("nq_busy", busy, 0);
        check("nq_mreq", mreq, 0);

        // reset in the middle of MEM
        req = 1; f3 = 3'b010; addr = 32'h700;
        step();
        req = 0;
        check("rs_pre", mreq, 1);
        #2 rst_n = 1'b0;
        #1;
        check("rs_mreq", mreq, 0);
        check("rs_busy", busy, 0);
        @(posedge clk);
        #1;
        check("rs_done", done, 0);

        // back-to-back loads with req and ack held high
        req = 1; f3 = 3'b010; addr = 32'h0; rdata = 32'h1234_5678; ack = 1;
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("b1_mreq", mreq, 1);
        step();
        check("b1_done", done, 1);
        check("b1_rd", rd, 32'h1234_5678);
        step();
        check("bg_done", done, 0);
        check("bg_mreq", mreq, 0);
        step();
        check("b2_mreq", mreq, 1);
        step();
        check("b2_done", done, 1);
        req = 0; ack = 0;
        step();

        // XLEN=64 LWU from the upper word
        req64 = 1; we64 = 0; f3_64 = 3'b110; addr64 = 32'h1004;
        rdata64 = 64'h8000_0001_0000_0000; ack64 = 1;
        step();
        req64 = 0;
        check("lwu_be", mbe64, 8'hF0);
        check("lwu_addr", maddr64, 32'h1000);
        step();
        check("lwu_done", done64, 1);
        check("lwu_rd", rd64, 64'h0000_0000_8000_0001);
        step();

        // XLEN=64 LW sign-extends the same word
        req64 = 1; f3_64 = 3'b010;
        step();
        req64 = 0;
        step();
        check("lw64_rd", rd64, 64'hFFFF_FFFF_8000_0001);
        ack64 = 0;
        step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/cpe_lsu.md
CPE_LSU -- requirements
Module: cpe_lsu

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning data width; legal values 32 or 64.
REQ-002 SHALL have parameter ADDR_W, default 32, meaning byte-address width.
REQ-003 SHALL have parameter TIMEOUT, default 255, meaning the maximum number of cycles to wait for mem_ack before aborting; range 1..65535.
REQ-004 SHALL have port clk_w_i, input, 1 bit: the single clock, rising edge.
REQ-005 SHALL have port res_w_i_l, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port req_w_i_h, input, 1 bit: CPU access request.
REQ-007 SHALL have port we_w_i_h, input, 1 bit: 1 = store, 0 = load.
REQ-008 SHALL have port funct_3_w_i, input, 3 bits: access size and sign, encoded as RV funct3.
REQ-009 SHALL have port addr_w_i, input, ADDR_W bits: byte address.
REQ-010 SHALL have port wr_data_w_i, input, XLEN bits: store data, right-aligned.
REQ-011 SHALL have port busy_w_o_h, output, 1 bit: a transaction is in flight.
REQ-012 SHALL have port done_w_o_h, output, 1 bit: one-cycle completion pulse.
REQ-013 SHALL have port rd_data_w_o, output, XLEN bits: extended load result.
REQ-014 SHALL have port misalign_w_o_h, output, 1 bit: alignment fault, valid while done is high.
REQ-015 SHALL have port err_w_o_h, output, 1 bit: bus error, timeout or illegal funct3, valid while done is high.
REQ-016 SHALL have port mem_req_w_o_h, output, 1 bit: memory request.
REQ-017 SHALL have port mem_wr_w_o_h, output, 1 bit: memory write strobe.
REQ-018 SHALL have port mem_addr_w_o, output, ADDR_W bits: lane-aligned address, with the low log2(XLEN/8) bits zero.
REQ-019 SHALL have port mem_be_w_o, output, XLEN/8 bits: byte enables.
REQ-020 SHALL have port mem_wdata_w_o, output, XLEN bits: lane-positioned store data.
REQ-021 SHALL have port mem_ack_w_i_h, input, 1 bit: memory accepts the request, or returns read data, in this cycle.
REQ-022 SHALL have port mem_rdata_w_i, input, XLEN bits: read data, valid with mem_ack.
REQ-023 SHALL have port mem_err_w_i_h, input, 1 bit: bus error, valid with mem_ack.

Function
REQ-024 SHALL implement a registered FSM with states IDLE, MEM, and DONE; all outputs SHALL be driven from registers.
REQ-025 In IDLE, req_w_i_h=1 SHALL latch we, funct3, addr and wr_data, set busy, and transition as follows: to DONE if the access is misaligned or funct3 is illegal, otherwise to MEM.
REQ-026 In IDLE, busy and done SHALL be low.
REQ-027 A req_w_i_h asserted while busy is high SHALL be ignored and SHALL NOT be queued.
REQ-028 Legal funct3 for loads SHALL be 000 LB, 001 LH, 010 LW, 100 LBU and 101 LHU; XLEN=64 additionally allows 011 LD and 110 LWU.
REQ-029 Legal funct3 for stores SHALL be 000, 001 and 010; XLEN=64 additionally allows 011.
REQ-030 Any other funct3 SHALL set err with no memory access.
REQ-031 An access of size 2^n bytes SHALL fault as misaligned when addr[n-1:0] is non-zero; misalign SHALL take precedence over illegal funct3.
REQ-032 In MEM, mem_req SHALL stay high, and mem_addr, mem_be, mem_wr and mem_wdata SHALL stay stable, until a cycle in which mem_ack is sampled high.
REQ-033 mem_be SHALL have the (2^n) bits starting at lane = addr[log2(XLEN/8)-1:0] set; mem_wdata SHALL equal wr_data shifted left by 8*lane bits.
REQ-034 When mem_ack is sampled high, the block SHALL go to DONE, capture the load result, and set err to mem_err.
REQ-035 The load result SHALL be the field taken from mem_rdata starting at byte lane, then sign-extended (signed ops) or zero-extended (U ops) to XLEN.
REQ-036 For stores, rd_data_w_o SHALL be zero.
REQ-037 A counter SHALL be cleared on entry to MEM and incremented each MEM cycle without ack.
REQ-038 When the counter reaches TIMEOUT, the block SHALL go to DONE with err=1 and drop mem_req.
REQ-039 If ack and timeout occur in the same cycle, the ack SHALL win.
REQ-040 DONE SHALL last exactly one cycle: done=1, busy=0, then return to IDLE.
REQ-041 misalign and err SHALL be cleared on leaving DONE.
REQ-042 Latency SHALL be as follows: request sampled at edge T, mem_req high after T, ack sampled at edge T+k, done high for one cycle after T+k; the minimum is 2 cycles. A fault path SHALL produce done one cycle after T.
REQ-043 A new req SHALL be accepted in the cycle immediately following DONE.

Reset
REQ-044 res_w_i_l=0 SHALL immediately, asynchronously, force IDLE and set all outputs and internal registers to zero.
REQ-045 A transaction in flight when reset asserts SHALL be abandoned with no done pulse; mem_req SHALL drop immediately.
REQ-046 Deassertion of reset SHALL be synchronised externally; the block SHALL accept req on the first edge after deassertion.

Verification
REQ-047 LB: XLEN=32, load, funct3=000, addr=0x103, mem_rdata=0x80FF_0000, ack on the first cycle -> mem_addr=0x100, mem_be=1000, rd_data=0xFFFF_FF80, done 2 cycles after req.
REQ-048 SH: store, funct3=001, addr=0x202, wr_data=0x0000_BEEF -> mem_be=1100, mem_wdata=0xBEEF_0000, mem_wr=1, rd_data=0.
REQ-049 Misaligned LW at addr=0x101 -> no mem_req ever, done with misalign=1 one cycle after req; illegal funct3=011 at XLEN=32 -> done with err=1.
REQ-050 Timeout: TIMEOUT=4, mem_ack held low -> mem_req high for 4 cycles, then done with err=1.
REQ-051 The same test with ack arriving in the 4th MEM cycle -> err=0.
REQ-052 Reset mid-MEM, then back-to-back loads: reset drops mem_req and busy with no done pulse; req held high continuously -> a new transaction starts on the cycle after each DONE.
REQ-053 XLEN=64 LWU: addr=0x1004, mem_rdata upper word=0x8000_0001 -> mem_be=0xF0, rd_data=0x0000_0000_8000_0001.
